// File: rtl/game_controller_pkg.sv
// Shared encodings and sizing constants for the tile-duel game controller.
package game_controller_pkg;

    // Display state codes; 3'b111 is never produced.
    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_RASP     = 3'b001,
        ST_BAWP     = 3'b010,
        ST_P1_TURN  = 3'b011,
        ST_P2_TURN  = 3'b100,
        ST_MATCH    = 3'b101,
        ST_GAME     = 3'b110
    } state_t;

    // Outcome codes shared by match and game results; 2'b11 is unused.
    typedef enum logic [1:0] {
        RES_P1   = 2'b00,
        RES_P2   = 2'b01,
        RES_DRAW = 2'b10
    } result_t;

    localparam int NUM_TILES  = 9;
    localparam int INIT_BLACK = 5;
    localparam int INIT_WHITE = 4;
    localparam int LAST_ROUND = 9;

    // Higher value wins from P1's point of view; equal values draw.
    function automatic result_t compare_vals(input logic [3:0] a, input logic [3:0] b);
        if (a > b)      return RES_P1;
        else if (a < b) return RES_P2;
        else            return RES_DRAW;
    endfunction

endpackage

// File: rtl/game_controller_ledger.sv
// Per-player tile bookkeeping: used mask, black/white counters and the
// legality check. A tile is consumed only when it is legal, so the
// counters can never underflow.
module tile_ledger
    import game_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       consume,
    input  logic [3:0] card,
    output logic       legal,
    output logic [3:0] black,
    output logic [3:0] white
);

    logic [NUM_TILES-1:0] used;
    logic [15:0]          used_ext;
    logic [NUM_TILES-1:0] card_bit;

    // Widen the mask so any 4-bit card value indexes safely.
    assign used_ext = {{(16 - NUM_TILES){1'b0}}, used};
    assign card_bit = NUM_TILES'(1) << card;
    assign legal    = (card < 4'(NUM_TILES)) && !used_ext[card];

    // Mark the tile used and decrement the counter matching its parity.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            used  <= '0;
            black <= 4'(INIT_BLACK);
            white <= 4'(INIT_WHITE);
        end else if (consume && legal) begin
            used <= used | card_bit;
            if (card[0]) white <= white - 4'd1;
            else         black <= black - 4'd1;
        end
    end

endmodule

// File: rtl/game_controller.sv
// Two-player tile duel: FSM, round and score counters, match comparator.
// Handshake: card_valid is a one-cycle strobe qualifying card_in and is only
// consumed in p1_turn/p2_turn; btn_next is a one-cycle pulse only consumed
// outside those states, so one cycle never acts on both.
module game_controller
    import game_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_next,
    input  logic       card_valid,
    input  logic [3:0] card_in,
    output logic [2:0] state,
    output logic [3:0] round,
    output logic [3:0] win,
    output logic [3:0] lose,
    output logic [3:0] p1_black,
    output logic [3:0] p1_white,
    output logic [3:0] p2_black,
    output logic [3:0] p2_white,
    output logic [3:0] p1_card,
    output logic [1:0] matchresult,
    output logic [1:0] gameresult,
    output logic       card_err
);

    state_t  st, st_next;
    logic    p1_legal, p2_legal;
    logic    p1_take, p2_take, bad_card, round_up, game_end, game_clear;
    result_t match_res;

    assign state     = st;
    assign match_res = compare_vals(p1_card, card_in);

    tile_ledger u_p1 (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (game_clear),
        .consume (p1_take),
        .card    (card_in),
        .legal   (p1_legal),
        .black   (p1_black),
        .white   (p1_white)
    );

    tile_ledger u_p2 (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (game_clear),
        .consume (p2_take),
        .card    (card_in),
        .legal   (p2_legal),
        .black   (p2_black),
        .white   (p2_white)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) st <= ST_INIT;
        else          st <= st_next;
    end

    // Next-state decode and per-cycle event strobes.
    always_comb begin
        st_next    = st;
        p1_take    = 1'b0;
        p2_take    = 1'b0;
        bad_card   = 1'b0;
        round_up   = 1'b0;
        game_end   = 1'b0;
        game_clear = 1'b0;
        case (st)
            ST_INIT: if (btn_next) st_next = ST_RASP;
            ST_RASP: if (btn_next) st_next = ST_BAWP;
            ST_BAWP: if (btn_next) st_next = ST_P1_TURN;
            ST_P1_TURN: if (card_valid) begin
                if (p1_legal) begin
                    p1_take = 1'b1;
                    st_next = ST_P2_TURN;
                end else begin
                    bad_card = 1'b1;
                end
            end
            ST_P2_TURN: if (card_valid) begin
                if (p2_legal) begin
                    p2_take = 1'b1;
                    st_next = ST_MATCH;
                end else begin
                    bad_card = 1'b1;
                end
            end
            ST_MATCH: if (btn_next) begin
                if (round < 4'(LAST_ROUND)) begin
                    round_up = 1'b1;
                    st_next  = ST_RASP;
                end else begin
                    game_end = 1'b1;
                    st_next  = ST_GAME;
                end
            end
            ST_GAME: if (btn_next) begin
                game_clear = 1'b1;
                st_next    = ST_INIT;
            end
            default: st_next = ST_INIT;
        endcase
    end

    // Round, score, accepted-card and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n || game_clear) begin
            round       <= 4'd1;
            win         <= 4'd0;
            lose        <= 4'd0;
            p1_card     <= 4'd0;
            matchresult <= RES_DRAW;
            gameresult  <= RES_DRAW;
            card_err    <= 1'b0;
        end else begin
            card_err <= bad_card;
            if (p1_take) p1_card <= card_in;
            if (p2_take) begin
                matchresult <= match_res;
                if (match_res == RES_P1) win  <= win + 4'd1;
                if (match_res == RES_P2) lose <= lose + 4'd1;
            end
            if (round_up) round <= round + 4'd1;
            if (game_end) begin
                if (win > lose)      gameresult <= RES_P1;
                else if (lose > win) gameresult <= RES_P2;
                else                 gameresult <= RES_DRAW;
            end
        end
    end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: port clk, then port reset_n.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 reset_n  in  1  synchronous active-low reset.
REQ-004 btn_next  in  1  single-cycle advance pulse, already debounced and edge-detected.
REQ-005 card_valid  in  1  single-cycle strobe qualifying card_in.
REQ-006 card_in  in  4  tile number played by the current player; legal range 0..8.
REQ-007 state  out  3  display state: init=000, rasp=001, bawp=010, p1_turn=011, p2_turn=100, matchresult_print=101, gameresult_print=110; 111 is never driven.
REQ-008 round  out  4  current round, 1..9.
REQ-009 win, lose  out  4 each  P1 rounds won and P1 rounds lost.
REQ-010 p1_black, p1_white, p2_black, p2_white  out  4 each  unplayed black (even) and white (odd) tiles per player.
REQ-011 p1_card  out  4  tile accepted from P1 in the current round; valid in p2_turn and matchresult_print.
REQ-012 matchresult, gameresult  out  2 each  00 = P1 wins, 01 = P2 wins, 10 = draw, 11 = unused.
REQ-013 card_err  out  1  one-cycle pulse, asserted the cycle after an illegal card strobe.

Function
REQ-014 Transitions on btn_next:
- init -> rasp
- rasp -> bawp
- bawp -> p1_turn
- matchresult_print -> rasp with round+1 when round<9; -> gameresult_print when round=9
- gameresult_print -> init
REQ-015 p1_turn: a legal card is accepted, the FSM enters p2_turn next cycle, p1_card is registered, the P1 used bit is set, and p1_black or p1_white is decremented by card parity.
REQ-016 p2_turn: a legal card is accepted, the FSM enters matchresult_print next cycle, P2 bookkeeping is updated, and matchresult is registered.
- higher tile wins; equal tiles draw
- win increments on 00; lose increments on 01; neither changes on a draw
REQ-017 A card is illegal when card_in>8 or its used bit is already set for the current player; the strobe then changes no state and card_err pulses.
REQ-018 card_valid is ignored outside p1_turn/p2_turn; btn_next is ignored in p1_turn/p2_turn; a simultaneous btn_next and card_valid is resolved by those two rules, never both acted upon.
REQ-019 On entry to gameresult_print, gameresult SHALL be 00 if win>lose, 01 if lose>win, and 10 if equal.
REQ-020 gameresult_print -> init SHALL reload all counters, used masks and results to their reset values.
REQ-021 Counters SHALL NOT wrap: round saturates at 9, and tile counts never go below 0 because used-mask checking precedes any decrement.
REQ-022 All outputs SHALL be registered; state-change latency from an accepted event is exactly 1 cycle.

Reset
REQ-023 While reset_n=0 at a clk edge, the outputs SHALL take these values:
- state=init, round=1
- win=lose=0
- p1_black=p2_black=5, p1_white=p2_white=4
- p1_card=0
- matchresult=gameresult=10
- card_err=0
- both used masks cleared
REQ-024 Reset asserted mid-game (any state, including while card_valid is high) SHALL take priority over every other event in that cycle.

Structure
REQ-025 A shared package SHALL hold:
- the 3-bit state encodings
- the 2-bit result encodings
- NUM_TILES=9, INIT_BLACK=5, INIT_WHITE=4, LAST_ROUND=9
REQ-026 A sub-module tile_ledger (9-bit used mask, black/white counters, legality check, parity decrement) SHALL be instantiated twice, once per player.
REQ-027 The FSM, round/score counters and comparator SHALL reside in game_controller; the display mux consumes state and the counter outputs unchanged.

Verification
REQ-028 Reset, then btn_next x3 -> state sequence 000, 001, 010, 011 on successive pulses; round=1, p1_black=5, p1_white=4.
REQ-029 In p1_turn play 7, then in p2_turn play 4 -> p1_card=7, p1_white=3, p2_black=4, matchresult=00, win=1, state=101.
REQ-030 In p1_turn play 9 (out of range), then replay an already-used tile 7 -> card_err pulses once per strobe, state stays 011, counts unchanged.
REQ-031 Both players play 3 -> matchresult=10, win and lose unchanged; hold btn_next together with card_valid in p2_turn -> only the card is acted upon.
REQ-032 Nine full rounds with P2 winning 5 of them -> after round 9, btn_next leads to 110 with gameresult=01; next btn_next -> init with all counters reloaded.
REQ-033 Assert reset_n=0 in p2_turn with card_valid high -> next cycle all outputs at reset values and no card recorded.
